// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, writeback source select and load funct3 encodings.
// Also defines the writeback stage's packed control record.
package cpu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } load_funct3_e;

    typedef struct packed {
        logic         valid;
        logic         reg_write;
        logic [4:0]   rd;
        wb_sel_e      wb_sel;
        load_funct3_e funct3;
    } wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: shifts the raw doubleword down by the byte offset,
// then sign/zero-extends by load type and flags misalignment or an illegal load type.
module load_align
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  load_funct3_e    funct3,
    output logic [XLEN-1:0] result,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        result     = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        unique case (funct3)
            F3_LB:  result = XLEN'($signed(shifted[7:0]));
            F3_LBU: result = XLEN'(shifted[7:0]);
            F3_LH: begin
                result     = XLEN'($signed(shifted[15:0]));
                misaligned = offset[0];
            end
            F3_LHU: begin
                result     = XLEN'(shifted[15:0]);
                misaligned = offset[0];
            end
            F3_LW: begin
                result     = XLEN'($signed(shifted[31:0]));
                misaligned = |offset[1:0];
            end
            F3_LWU: begin
                result     = XLEN'(shifted[31:0]);
                misaligned = |offset[1:0];
            end
            F3_LD: begin
                result     = shifted;
                misaligned = |offset;
            end
            F3_ILL: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: registers the MEM-stage result, formats loads, drives the
// register-file write port and keeps the retired-instruction counter.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            wb_stall,
    input  logic            wb_flush,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data,
    output logic            wb_valid,
    output logic            misalign_err,
    output logic [63:0]     instret
);

    wb_ctrl_t        ctrl_q, ctrl_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [63:0]     instret_q, instret_d;

    logic [XLEN-1:0] load_result;
    logic            load_misaligned;
    logic            load_illegal;
    logic            is_load;
    logic            load_fault;

    // A flush kills the captured entry even while stalled; data fields follow the stall.
    always_comb begin
        ctrl_d       = ctrl_q;
        alu_result_d = alu_result_q;
        load_data_d  = load_data_q;
        pc_plus4_d   = pc_plus4_q;
        if (!wb_stall) begin
            ctrl_d.valid     = mem_valid;
            ctrl_d.reg_write = mem_reg_write;
            ctrl_d.rd        = mem_rd;
            ctrl_d.wb_sel    = wb_sel_e'(mem_wb_sel);
            ctrl_d.funct3    = load_funct3_e'(mem_funct3);
            alu_result_d     = mem_alu_result;
            load_data_d      = mem_load_data;
            pc_plus4_d       = mem_pc_plus4;
        end
        if (wb_flush) begin
            ctrl_d.valid = 1'b0;
        end
    end

    // Every held valid entry retires when the stage advances, faulting or not; wraps naturally.
    always_comb begin
        instret_d = instret_q;
        if (ctrl_q.valid && !wb_stall) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            alu_result_q <= '0;
            load_data_q  <= '0;
            pc_plus4_q   <= '0;
            instret_q    <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_result_q <= alu_result_d;
            load_data_q  <= load_data_d;
            pc_plus4_q   <= pc_plus4_d;
            instret_q    <= instret_d;
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .data       (load_data_q),
        .offset     (alu_result_q[2:0]),
        .funct3     (ctrl_q.funct3),
        .result     (load_result),
        .misaligned (load_misaligned),
        .illegal    (load_illegal)
    );

    always_comb begin
        is_load    = (ctrl_q.wb_sel == WB_LOAD);
        load_fault = is_load && (load_misaligned || load_illegal);

        write_data = '0;
        unique case (ctrl_q.wb_sel)
            WB_ALU:  write_data = alu_result_q;
            WB_LOAD: write_data = load_result;
            WB_PC4:  write_data = pc_plus4_q;
            WB_RSVD: write_data = '0;
        endcase

        // Stays asserted through a stall; rewriting the same value is harmless.
        reg_write = ctrl_q.valid && ctrl_q.reg_write && (ctrl_q.rd != 5'd0)
                    && (ctrl_q.wb_sel != WB_RSVD) && !load_fault;
        misalign_err = ctrl_q.valid && is_load && load_misaligned;
    end

    assign rd       = ctrl_q.rd;
    assign wb_valid = ctrl_q.valid;
    assign instret  = instret_q;

endmodule
